// File: rtl/bmf_part_err_sweeper.sv
// Exhaustive input sweeper and error accumulator for one exact/approximate partition pair.
// Optional ERR_THRESH_EN adds an early stop once the mismatch count exceeds a threshold.
module bmf_part_err_sweeper #(
   parameter int N_IN  = 9,
   parameter int N_OUT = 4,
   parameter int LAT   = 0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   abort,
   output logic [N_IN-1:0]        vec_o,
   output logic                   vec_vld,
   input  logic [N_OUT-1:0]       exact_po,
   input  logic [N_OUT-1:0]       approx_po,
`ifdef ERR_THRESH_EN
   input  logic [N_IN:0]          thresh,
   output logic                   err_exceed,
`endif
   output logic                   busy,
   output logic                   done,
   output logic                   aborted,
   output logic [N_IN:0]          mis_cnt,
   output logic [N_IN+2:0]        ham_sum,
   output logic [N_IN+N_OUT-1:0]  err_sum,
   output logic [N_OUT-1:0]       max_err
);

   localparam int MW = N_IN + 1;
   localparam int HW = N_IN + 3;
   localparam int EW = N_IN + N_OUT;
   localparam int DW = $clog2(LAT + 2);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SWEEP,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t          state, state_n;
   logic            accept;
   logic            abort_flush;
   logic            cmp_vld;
   logic            upd;
   logic            trip;
   logic [DW-1:0]   drain_cnt;

   logic [N_OUT-1:0] diff, xor_v;
   logic [HW-1:0]    pop;
   logic [MW:0]      mis_add;
   logic [HW:0]      ham_add;
   logic [EW:0]      err_add;
   logic [MW-1:0]    mis_next;
   logic [HW-1:0]    ham_next;
   logic [EW-1:0]    err_next;
   logic [N_OUT-1:0] max_next;

   assign busy        = (state == S_SWEEP) || (state == S_DRAIN);
   assign done        = (state == S_DONE);
   assign abort_flush = busy && abort;
   // An abort also drops the compare arriving in the same cycle.
   assign upd         = cmp_vld && !abort_flush;

   generate
      if (LAT == 0) begin : g_nopipe
         assign cmp_vld = vec_vld;
      end else begin : g_pipe
         logic [LAT-1:0] vld_pipe;
         always_ff @(posedge clk) begin
            if (!rst_n || abort_flush || trip) vld_pipe <= '0;
            else                               vld_pipe <= (vld_pipe << 1) | LAT'(vec_vld);
         end
         assign cmp_vld = vld_pipe[LAT-1];
      end
   endgenerate

   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      xor_v = exact_po ^ approx_po;
      diff  = (exact_po >= approx_po) ? (exact_po - approx_po) : (approx_po - exact_po);
      pop   = '0;
      for (int i = 0; i < N_OUT; i++) pop = pop + HW'(xor_v[i]);
      mis_add  = {1'b0, mis_cnt} + (MW+1)'(xor_v != '0);
      ham_add  = {1'b0, ham_sum} + {1'b0, pop};
      err_add  = {1'b0, err_sum} + (EW+1)'(diff);
      mis_next = mis_add[MW] ? '1 : mis_add[MW-1:0];
      ham_next = ham_add[HW] ? '1 : ham_add[HW-1:0];
      err_next = err_add[EW] ? '1 : err_add[EW-1:0];
      max_next = (diff > max_err) ? diff : max_err;
   end

`ifdef ERR_THRESH_EN
   assign trip = upd && (mis_next > thresh);
`else
   assign trip = 1'b0;
`endif

   always_comb begin
      state_n = state;
      accept  = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (start && !abort) begin
               accept  = 1'b1;
               state_n = S_SWEEP;
            end
         end
         S_SWEEP: begin
            if (abort)            state_n = S_IDLE;
            else if (vec_o == '1) state_n = S_DRAIN;
         end
         S_DRAIN: begin
            if (abort)                      state_n = S_IDLE;
            else if (drain_cnt == DW'(LAT)) state_n = S_DONE;
         end
         S_DONE: state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
      if (trip) state_n = S_DONE;
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) state <= S_IDLE;
      else        state <= state_n;
   end

   always_ff @(posedge clk) begin
      if (!rst_n || state != S_DRAIN) drain_cnt <= '0;
      else                            drain_cnt <= drain_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vec_o   <= '0;
         vec_vld <= 1'b0;
      end else if (accept) begin
         vec_o   <= '0;
         vec_vld <= 1'b1;
      end else if (state == S_SWEEP) begin
         if (abort_flush || trip || vec_o == '1) vec_vld <= 1'b0;
         else                                     vec_o   <= vec_o + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mis_cnt <= '0;
         ham_sum <= '0;
         err_sum <= '0;
         max_err <= '0;
         aborted <= 1'b0;
      end else if (accept) begin
         mis_cnt <= '0;
         ham_sum <= '0;
         err_sum <= '0;
         max_err <= '0;
         aborted <= 1'b0;
      end else begin
         if (abort_flush) aborted <= 1'b1;
         if (upd) begin
            mis_cnt <= mis_next;
            ham_sum <= ham_next;
            err_sum <= err_next;
            max_err <= max_next;
         end
      end
   end

`ifdef ERR_THRESH_EN
   always_ff @(posedge clk) begin
      if (!rst_n || accept) err_exceed <= 1'b0;
      else if (trip)        err_exceed <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_bmf_part_err_sweeper.sv
// Directed bench: one LAT=0 and one LAT=2 sweeper driven side by side from shared stimulus.
module tb_bmf_part_err_sweeper;

   logic clk = 1'b0;
   logic rst_n, start, abort;
   int   mode;
   int   checks = 0;
   int   errors = 0;

   logic [8:0]  vec0, vec2, v2d1, v2d2;
   logic        vld0, vld2, busy0, busy2, done0, done2, ab0, ab2;
   logic [3:0]  ex0, ap0, ex2, ap2, max0, max2;
   logic [9:0]  mis0, mis2;
   logic [11:0] ham0, ham2;
   logic [12:0] err0, err2;
`ifdef ERR_THRESH_EN
   logic        exc0, exc2;
`endif

   always #5 clk = ~clk;

   function automatic logic [3:0] f_ap(input logic [8:0] v, input int m);
      case (m)
         0:       return v[3:0];
         1:       return v[3:0] ^ 4'b0001;
         default: return 4'b0000;
      endcase
   endfunction

   assign ex0 = vec0[3:0];
   assign ap0 = f_ap(vec0, mode);
   always @(posedge clk) begin
      v2d1 <= vec2;
      v2d2 <= v2d1;
   end
   assign ex2 = v2d2[3:0];
   assign ap2 = f_ap(v2d2, mode);

   bmf_part_err_sweeper #(.N_IN(9), .N_OUT(4), .LAT(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .vec_o(vec0), .vec_vld(vld0), .exact_po(ex0), .approx_po(ap0),
`ifdef ERR_THRESH_EN
      .thresh(10'h3ff), .err_exceed(exc0),
`endif
      .busy(busy0), .done(done0), .aborted(ab0),
      .mis_cnt(mis0), .ham_sum(ham0), .err_sum(err0), .max_err(max0));

   bmf_part_err_sweeper #(.N_IN(9), .N_OUT(4), .LAT(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .vec_o(vec2), .vec_vld(vld2), .exact_po(ex2), .approx_po(ap2),
`ifdef ERR_THRESH_EN
      .thresh(10'h3ff), .err_exceed(exc2),
`endif
      .busy(busy2), .done(done2), .aborted(ab2),
      .mis_cnt(mis2), .ham_sum(ham2), .err_sum(err2), .max_err(max2));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Runs one full sweep for a fixed 600-cycle window, cycle 0 being the start cycle.
   task automatic run_sweep(input int m, output int dc0, output int dc2, output int dn0,
                            output int dn2, output int nvld, output int first_v,
                            output int last_v, output logic seq_ok);
      int exp_vec;
      mode = m;
      dc0 = -1; dc2 = -1; dn0 = 0; dn2 = 0; nvld = 0; first_v = -1; last_v = -1;
      seq_ok = 1'b1; exp_vec = 0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int c = 1; c < 600; c++) begin
         if (vld0) begin
            if (vec0 !== 9'(exp_vec)) seq_ok = 1'b0;
            exp_vec++;
            nvld++;
            if (first_v < 0) first_v = c;
            last_v = c;
         end
         if (done0) begin dn0++; if (dc0 < 0) dc0 = c; end
         if (done2) begin dn2++; if (dc2 < 0) dc2 = c; end
         @(negedge clk);
      end
   endtask

   int dc0, dc2, dn0, dn2, nvld, fv, lv, seen_done;
   logic seq_ok;

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 0;
      repeat (3) @(negedge clk);
      check("rst_vec_o", 32'(vec0), 0);
      check("rst_vec_vld", 32'(vld0), 0);
      check("rst_busy", 32'(busy0), 0);
      check("rst_done", 32'(done0), 0);
      check("rst_aborted", 32'(ab0), 0);
      check("rst_mis", 32'(mis0), 0);
      check("rst_ham", 32'(ham0), 0);
      check("rst_err", 32'(err0), 0);
      check("rst_max", 32'(max0), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Identical outputs: no error, baseline timing.
      run_sweep(0, dc0, dc2, dn0, dn2, nvld, fv, lv, seq_ok);
      check("s0_done_cyc_lat0", 32'(dc0), 514);
      check("s0_done_cyc_lat2", 32'(dc2), 516);
      check("s0_done_width0", 32'(dn0), 1);
      check("s0_done_width2", 32'(dn2), 1);
      check("s0_vld_count", 32'(nvld), 512);
      check("s0_first_vld", 32'(fv), 1);
      check("s0_last_vld", 32'(lv), 512);
      check("s0_seq", 32'(seq_ok), 1);
      check("s0_mis", 32'(mis0), 0);
      check("s0_ham", 32'(ham0), 0);
      check("s0_err", 32'(err0), 0);
      check("s0_max", 32'(max0), 0);
      check("s0_busy_idle", 32'(busy0), 0);

      // LSB flipped on every vector.
      run_sweep(1, dc0, dc2, dn0, dn2, nvld, fv, lv, seq_ok);
      check("s1_mis0", 32'(mis0), 512);
      check("s1_ham0", 32'(ham0), 512);
      check("s1_err0", 32'(err0), 512);
      check("s1_max0", 32'(max0), 1);
      check("s1_mis2", 32'(mis2), 512);
      check("s1_err2", 32'(err2), 512);
      repeat (3) @(negedge clk);
      check("s1_hold_mis0", 32'(mis0), 512);

      // Abort mid-sweep; a start while busy must not restart the counter.
      mode = 1;
      seen_done = 0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int c = 1; c <= 110; c++) begin
         if (c == 50) start = 1'b1;
         if (c == 51) begin
            check("busy_start_ignored", 32'(vec0), 50);
            start = 1'b0;
         end
         if (c == 101) begin
            check("abort_vec_o", 32'(vec0), 100);
            abort = 1'b1;
         end
         if (c == 102) begin
            abort = 1'b0;
            check("abort_busy0", 32'(busy0), 0);
            check("abort_busy2", 32'(busy2), 0);
            check("abort_flag0", 32'(ab0), 1);
            check("abort_flag2", 32'(ab2), 1);
            check("abort_vld0", 32'(vld0), 0);
            check("abort_mis0_range", 32'(mis0 >= 10'd99 && mis0 <= 10'd100), 1);
            check("abort_mis2_range", 32'(mis2 >= 10'd97 && mis2 <= 10'd100), 1);
         end
         if (done0 || done2) seen_done++;
         @(negedge clk);
      end
      check("abort_no_done", 32'(seen_done), 0);

      // Start and abort together in IDLE: nothing starts, aborted stays sticky.
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      check("startabort_busy", 32'(busy0), 0);
      check("startabort_vld", 32'(vld0), 0);
      check("startabort_sticky", 32'(ab0), 1);
      @(negedge clk);

      // Approximation stuck at zero.
      run_sweep(2, dc0, dc2, dn0, dn2, nvld, fv, lv, seq_ok);
      check("s2_aborted_cleared", 32'(ab0), 0);
      check("s2_mis0", 32'(mis0), 480);
      check("s2_ham0", 32'(ham0), 1024);
      check("s2_err0", 32'(err0), 3840);
      check("s2_max0", 32'(max0), 15);
      check("s2_mis2", 32'(mis2), 480);
      check("s2_ham2", 32'(ham2), 1024);
      check("s2_err2", 32'(err2), 3840);
      check("s2_max2", 32'(max2), 15);
      check("s2_done_lat0", 32'(dc0), 514);
      check("s2_done_lat2", 32'(dc2), 516);

      // Reset in the middle of a sweep discards everything.
      mode = 2;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (20) @(negedge clk);
      check("midrst_busy_before", 32'(busy0), 1);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_busy", 32'(busy0), 0);
      check("midrst_vld", 32'(vld0), 0);
      check("midrst_vec", 32'(vec0), 0);
      check("midrst_mis", 32'(mis0), 0);
      check("midrst_err2", 32'(err2), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
